// File: rtl/ids_rr_arbiter.sv
// Packet-boundary round-robin arbiter sharing one ids datapath stage between two 64b streams.
// Optional per-source packet counters are enabled with the IDS_ARB_STATS_EN macro.
module ids_rr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic [CTRL_WIDTH-1:0] in0_ctrl,
    input  logic                  in0_wr,
    input  logic                  in0_req,
    output logic                  in0_rdy,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic [CTRL_WIDTH-1:0] in1_ctrl,
    input  logic                  in1_wr,
    input  logic                  in1_req,
    output logic                  in1_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [1:0]            grant,
    output logic                  proto_err
`ifdef IDS_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] pkt_cnt0,
    output logic [STAT_WIDTH-1:0] pkt_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;     // 1: source 1 owned the previous packet
    logic       perr_q, perr_d;
    logic       busy, acc0, acc1, eop;

    assign busy    = (state_q != IDLE);
    assign in0_rdy = busy & grant_q[0] & out_rdy;
    assign in1_rdy = busy & grant_q[1] & out_rdy;
    assign acc0    = in0_wr & in0_rdy;
    assign acc1    = in1_wr & in1_rdy;

    // Zero-latency forwarding; bus idles at zero when nothing is accepted
    always_comb begin
        out_wr   = acc0 | acc1;
        out_data = '0;
        out_ctrl = '0;
        if (acc0) begin
            out_data = in0_data;
            out_ctrl = in0_ctrl;
        end else if (acc1) begin
            out_data = in1_data;
            out_ctrl = in1_ctrl;
        end
    end

    assign eop       = out_wr && (state_q == PAY) && (out_ctrl != '0);
    assign grant     = grant_q;
    assign proto_err = perr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        perr_d  = perr_q | (in0_wr & ~in0_rdy) | (in1_wr & ~in1_rdy);
        case (state_q)
            IDLE: begin
                if (in0_req | in1_req) begin
                    state_d = HDR;
                    if (in0_req & in1_req) grant_d = last_q ? 2'b01 : 2'b10;
                    else                   grant_d = in0_req ? 2'b01 : 2'b10;
                end
            end
            HDR: begin
                if (out_wr && (out_ctrl == '0)) state_d = PAY;
            end
            PAY: begin
                if (eop) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

`ifdef IDS_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] cnt0_q, cnt1_q;

    // Counters wrap naturally at 2^STAT_WIDTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (eop) begin
            if (grant_q[0]) cnt0_q <= cnt0_q + STAT_WIDTH'(1);
            if (grant_q[1]) cnt1_q <= cnt1_q + STAT_WIDTH'(1);
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
`else
    // No statistics state in this build; the width parameter is intentionally unused
    logic unused_stat_width;
    assign unused_stat_width = |STAT_WIDTH;
`endif

endmodule
